// File: rtl/ad_cache_pkg.sv
// ad_cache_pkg: shared widths, sizes and state codes for the ADC sample cache
package ad_cache_pkg;
   localparam int AD_DATA_NBIT = 16;
   localparam int AD_CHN_NBIT = 3;
   localparam int AD_CHE_DATA_SIZE = 256;
   localparam int AD_CHE_ADDR_NBIT = $clog2(AD_CHE_DATA_SIZE);
   localparam logic HIGH = 1'b1;
   localparam logic LOW = 1'b0;
   typedef enum logic {ST_AC_IDLE, ST_AC_FILL} ac_state_t;
endpackage

// File: rtl/ad_cache_ram.sv
// ad_cache_ram: simple dual-port RAM with registered read, block-RAM friendly
module ad_cache_ram #(
   parameter int P_DATA_NBIT = 16,
   parameter int P_ADDR_NBIT = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [P_ADDR_NBIT-1:0] wr_addr,
   input  logic [P_DATA_NBIT-1:0] wr_data,
   input  logic [P_ADDR_NBIT-1:0] rd_addr,
   output logic [P_DATA_NBIT-1:0] rd_data
);
   logic [P_DATA_NBIT-1:0] mem [2**P_ADDR_NBIT];
   // write port
   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= wr_data;
   // registered read port, cleared on reset
   always_ff @(posedge clk or posedge rst)
      if (rst) rd_data <= '0;
      else rd_data <= mem[rd_addr];
endmodule

// File: rtl/ad_cache.sv
// ad_cache: ping-pong ADC sample cache feeding the USB TX stage through a FWFT read port
module ad_cache
   import ad_cache_pkg::*;
#(
   parameter int P_DATA_NBIT = AD_DATA_NBIT,
   parameter int P_CHN_NBIT = AD_CHN_NBIT,
   parameter int P_DEPTH = AD_CHE_DATA_SIZE
) (
   input  logic                   mclk,
   input  logic                   rst,
   input  logic                   sync,
   input  logic [P_DATA_NBIT-1:0] adc_din,
   input  logic [P_CHN_NBIT-1:0]  adc_din_chn,
   input  logic                   ad_acq_en,
   input  logic [P_CHN_NBIT-1:0]  ad_chn,
   input  logic                   ad_rd,
   output logic [P_DATA_NBIT-1:0] ad_data,
   output logic                   ad_switch,
   output logic                   ad_ovf
);
   localparam int AW = $clog2(P_DEPTH);
   localparam logic [AW-1:0] LAST = '1;
   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
   ac_state_t state, state_nxt;
   logic [2:0] p_sync;
   logic [P_CHN_NBIT-1:0] chn_q;
   logic acq_q, wr_bank, rd_bank, cap, chg, we, done, rd_ok;
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [AW:0] rd_cnt;
   // edge detect, write qualification, read pointer look-ahead and next state
   always_comb begin
      cap = p_sync[1] & ~p_sync[2];
      chg = ad_chn != chn_q;
      we = (state == ST_AC_FILL) & ad_acq_en & ~chg & cap & (adc_din_chn == ad_chn);
      done = we & (wr_ptr == LAST);
      rd_ok = ad_rd & ~rd_cnt[AW];
      rd_ptr_nxt = rd_ptr + {{(AW-1){1'b0}}, rd_ok & (rd_ptr != LAST)};
      state_nxt = ad_acq_en ? ST_AC_FILL : ST_AC_IDLE;
   end
   // state register
   always_ff @(posedge mclk or posedge rst)
      if (rst) state <= ST_AC_IDLE;
      else state <= state_nxt;
   // pointers, bank swap, switch pulse and sticky overflow; a completed bank pre-empts any read
   always_ff @(posedge mclk or posedge rst)
      if (rst) begin
         p_sync <= '0;
         chn_q <= '0;
         acq_q <= LOW;
         wr_bank <= LOW;
         rd_bank <= HIGH;
         wr_ptr <= '0;
         rd_ptr <= '0;
         rd_cnt <= FULL;
         ad_switch <= LOW;
         ad_ovf <= LOW;
      end else begin
         p_sync <= {p_sync[1:0], sync};
         chn_q <= ad_chn;
         acq_q <= ad_acq_en;
         ad_switch <= done;
         if (done) begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_cnt <= '0;
            if (~rd_cnt[AW]) ad_ovf <= HIGH;
         end else begin
            if (state == ST_AC_IDLE && ad_acq_en) begin
               wr_ptr <= '0;
               wr_bank <= ~rd_bank;
            end else if (state == ST_AC_IDLE || !ad_acq_en || chg) wr_ptr <= '0;
            else if (we) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            if (rd_ok) rd_cnt <= rd_cnt + 1'b1;
            if (ad_acq_en && !acq_q) ad_ovf <= LOW;
         end
      end
   ad_cache_ram #(.P_DATA_NBIT(P_DATA_NBIT), .P_ADDR_NBIT(AW + 1)) u_ram (
      .clk(mclk),
      .rst(rst),
      .we(we),
      .wr_addr({wr_bank, wr_ptr}),
      .wr_data(adc_din),
      .rd_addr({rd_bank, rd_ptr_nxt}),
      .rd_data(ad_data)
   );
endmodule

// File: tb/tb_ad_cache.sv
// tb_ad_cache: scoreboard bench for the ping-pong ADC sample cache
module tb_ad_cache;
   localparam int DW = 16;
   localparam int CW = 3;
   localparam int D = 4;
   logic mclk = 1'b0, rst = 1'b1, sync = 1'b0, ad_acq_en = 1'b0, ad_rd = 1'b0;
   logic ad_switch, ad_ovf;
   logic [DW-1:0] adc_din = '0, ad_data;
   logic [CW-1:0] adc_din_chn = '0, ad_chn = 3'd2;
   int checks = 0, errors = 0, sw_cnt = 0, exp_sw = 0;
   logic sw_prev = 1'b0, exp_ovf = 1'b0, m_acq = 1'b0;
   logic [DW-1:0] pend[$], expq[$];
   logic [CW-1:0] tags [4] = '{3'd1, 3'd2, 3'd3, 3'd2};

   ad_cache #(.P_DATA_NBIT(DW), .P_CHN_NBIT(CW), .P_DEPTH(D)) dut (
      .mclk(mclk),
      .rst(rst),
      .sync(sync),
      .adc_din(adc_din),
      .adc_din_chn(adc_din_chn),
      .ad_acq_en(ad_acq_en),
      .ad_chn(ad_chn),
      .ad_rd(ad_rd),
      .ad_data(ad_data),
      .ad_switch(ad_switch),
      .ad_ovf(ad_ovf)
   );

   always #5 mclk = ~mclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, want);
      end
   endtask

   // count switch pulses and require each to last a single cycle
   always @(negedge mclk) begin
      if (!rst && ad_switch) begin
         check("sw_width", {31'd0, sw_prev}, 0);
         sw_cnt++;
      end
      sw_prev = ad_switch & ~rst;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge mclk);
   endtask

   task automatic chk();
      check("sw_cnt", sw_cnt, exp_sw);
      check("ovf", {31'd0, ad_ovf}, {31'd0, exp_ovf});
   endtask

   task automatic cap(input logic [CW-1:0] t, input logic [DW-1:0] d);
      adc_din = d;
      adc_din_chn = t;
      sync = 1'b1;
      tick(4);
      sync = 1'b0;
      tick(4);
      if (m_acq && t == ad_chn) begin
         pend.push_back(d);
         if (pend.size() == D) begin
            if (expq.size() != 0) exp_ovf = 1'b1;
            expq = pend;
            pend.delete();
            exp_sw++;
         end
      end
   endtask

   task automatic set_acq(input logic v);
      if (v && !m_acq) exp_ovf = 1'b0;
      pend.delete();
      m_acq = v;
      ad_acq_en = v;
      tick(2);
   endtask

   task automatic set_chn(input logic [CW-1:0] c);
      if (c != ad_chn) pend.delete();
      ad_chn = c;
      tick(2);
   endtask

   task automatic drain(input int n);
      logic [DW-1:0] w;
      w = '0;
      check("avail", {31'd0, expq.size() >= n}, 1);
      ad_rd = 1'b1;
      for (int i = 0; i < n && expq.size() > 0; i++) begin
         w = expq.pop_front();
         check("data", {16'd0, ad_data}, {16'd0, w});
         tick();
      end
      if (expq.size() == 0) begin
         tick();
         ad_rd = 1'b0;
         tick();
         check("hold", {16'd0, ad_data}, {16'd0, w});
      end else ad_rd = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_data", {16'd0, ad_data}, 0);
      check("rst_sw", {31'd0, ad_switch}, 0);
      check("rst_ovf", {31'd0, ad_ovf}, 0);
      pend.delete();
      expq.delete();
      exp_ovf = 1'b0;
      @(negedge mclk) rst = 1'b0;
      tick(2);
      chk();
   endtask

   initial begin
      tick(2);
      #2;
      check("rst_data", {16'd0, ad_data}, 0);
      check("rst_sw", {31'd0, ad_switch}, 0);
      check("rst_ovf", {31'd0, ad_ovf}, 0);
      @(negedge mclk) rst = 1'b0;
      set_acq(1'b1);
      for (int i = 0; i < 4; i++) cap(3'd2, 16'(16'h0011 + i));
      chk();
      drain(4);
      chk();
      for (int i = 0; i < 8; i++) cap(tags[i % 4], 16'(16'h0100 + i));
      chk();
      drain(4);
      chk();
      for (int i = 8; i < 16; i++) cap(tags[i % 4], 16'(16'h0100 + i));
      chk();
      drain(4);
      chk();
      for (int i = 0; i < 4; i++) cap(3'd2, 16'(16'h0200 + i));
      for (int i = 0; i < 4; i++) cap(3'd2, 16'(16'h0300 + i));
      chk();
      drain(4);
      chk();
      set_acq(1'b0);
      set_acq(1'b1);
      chk();
      cap(3'd2, 16'h0400);
      cap(3'd2, 16'h0401);
      set_chn(3'd5);
      chk();
      for (int i = 0; i < 4; i++) cap(3'd5, 16'(16'h0500 + i));
      chk();
      drain(4);
      for (int i = 0; i < 3; i++) cap(3'd5, 16'(16'h0600 + i));
      set_acq(1'b0);
      set_acq(1'b1);
      chk();
      for (int i = 0; i < 3; i++) cap(3'd5, 16'(16'h0700 + i));
      chk();
      cap(3'd5, 16'h0703);
      chk();
      drain(4);
      cap(3'd5, 16'h0800);
      cap(3'd5, 16'h0801);
      do_reset();
      for (int i = 0; i < 4; i++) cap(3'd5, 16'(16'h0900 + i));
      chk();
      drain(2);
      do_reset();
      for (int i = 0; i < 4; i++) cap(3'd5, 16'(16'h0a00 + i));
      chk();
      drain(4);
      chk();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
